// File: rtl/qspi_flash_emu_pkg.sv
// qspi_flash_emu_pkg: shared states, opcodes and lane modes
// for the QSPI NOR-flash slave emulator.
package qspi_flash_emu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_DUMMY  = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_IGNORE = 3'd5;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_FAST = 8'h0B;
    localparam logic [7:0] OP_QOUT = 8'h6B;
    localparam logic [7:0] OP_QIO  = 8'hEB;
    localparam logic [7:0] OP_RDID = 8'h9F;

    typedef enum logic {
        SINGLE = 1'b0,
        QUAD   = 1'b1
    } lane_t;

    function automatic logic [7:0] id_byte(
        input logic [23:0] id,
        input logic [1:0]  idx
    );
        unique case (idx)
            2'd0:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            default: id_byte = id[7:0];
        endcase
    endfunction

endpackage

// File: rtl/qspi_flash_emu_if.sv
// qspi_flash_emu_if: QSPI pad bundle between a bus master
// (SoC controller or bench) and the flash emulator.
interface qspi_flash_emu_if;
    logic       qspi_cs_n;
    logic       qspi_sck;
    logic [3:0] qspi_dq_i;
    logic [3:0] qspi_dq_o;
    logic [3:0] qspi_dq_oe;

    modport master (
        output qspi_cs_n,
        output qspi_sck,
        output qspi_dq_i,
        input  qspi_dq_o,
        input  qspi_dq_oe
    );

    modport slave (
        input  qspi_cs_n,
        input  qspi_sck,
        input  qspi_dq_i,
        output qspi_dq_o,
        output qspi_dq_oe
    );
endinterface

// File: rtl/qspi_emu_sync.sv
// qspi_emu_sync: 2-flop synchronizer with rise/fall detect
// taken from the synchronized history.
module qspi_emu_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= RST_VAL;
            r_s2   <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_prev;
    assign o_fall = ~r_s2 & r_prev;
endmodule

// File: rtl/qspi_flash_emu.sv
// qspi_flash_emu: oversampled QSPI NOR-flash read emulator.
// Quad modes (0x6B/0xEB) built only with QSPI_FLASH_EMU_QUAD_EN.
module qspi_flash_emu
    import qspi_flash_emu_pkg::*;
#(
    parameter int          ADDR_W     = 24,
    parameter int          MEM_AW     = 20,
    parameter int          FAST_DUMMY = 8,
    parameter int          QIO_DUMMY  = 6,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
    input  logic              clk,
    input  logic              rst,
    qspi_flash_emu_if.slave   bus,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);
    logic       w_cs;
    logic       w_cs_rise;
    logic       w_cs_fall;
    logic       w_sck_q;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic [3:0] w_dq;
    logic [3:0] w_dq_rise;
    logic [3:0] w_dq_fall;

    qspi_emu_sync #(.W(1), .RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.qspi_cs_n),
        .o_q    (w_cs),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    qspi_emu_sync #(.W(1), .RST_VAL(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.qspi_sck),
        .o_q    (w_sck_q),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    qspi_emu_sync #(.W(4), .RST_VAL(4'h0)) u_sync_dq (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.qspi_dq_i),
        .o_q    (w_dq),
        .o_rise (w_dq_rise),
        .o_fall (w_dq_fall)
    );

    logic [8:0] w_unused_sync;
    assign w_unused_sync = {w_sck_q, w_dq_rise, w_dq_fall};

    state_t            r_state;
    logic [6:0]        r_cmd;
    logic [7:0]        r_cnt;
    logic [MEM_AW-2:0] r_addr;
    lane_t             r_lane;
    logic              r_qaddr;
    logic              r_rdid;
    logic [7:0]        r_dummy_n;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit;
    logic [1:0]        r_id;
    logic              r_ld;
    logic [3:0]        r_dq_o;
    logic [3:0]        r_dq_oe;
    logic              r_rd_en;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_cmd_err;

    logic [7:0]        w_cmd_nx;
    logic [MEM_AW-1:0] w_addr_nx;
    logic [7:0]        w_alast;
    logic              w_ok;
    lane_t             w_lane;
    logic              w_qaddr;
    logic              w_rdid;
    logic [7:0]        w_dn;
    logic              w_last_bit;

    assign w_cmd_nx  = {r_cmd, w_dq[0]};
    assign w_addr_nx = r_qaddr ? {r_addr[MEM_AW-5:0], w_dq}
                               : {r_addr, w_dq[0]};
    assign w_alast   = r_qaddr ? 8'(ADDR_W / 4 - 1)
                               : 8'(ADDR_W - 1);
    assign w_last_bit = (r_lane == QUAD) ? (r_bit == 3'd1)
                                         : (r_bit == 3'd7);

`ifndef QSPI_FLASH_EMU_QUAD_EN
    localparam int w_unused_qio = QIO_DUMMY;
`endif

    always_comb begin
        w_ok    = 1'b0;
        w_lane  = SINGLE;
        w_qaddr = 1'b0;
        w_rdid  = 1'b0;
        w_dn    = 8'd0;
        unique case (1'b1)
            (w_cmd_nx == OP_READ): w_ok = 1'b1;
            (w_cmd_nx == OP_FAST): begin
                w_ok = 1'b1;
                w_dn = 8'(FAST_DUMMY);
            end
`ifdef QSPI_FLASH_EMU_QUAD_EN
            (w_cmd_nx == OP_QOUT): begin
                w_ok   = 1'b1;
                w_lane = QUAD;
                w_dn   = 8'(FAST_DUMMY);
            end
            (w_cmd_nx == OP_QIO): begin
                w_ok    = 1'b1;
                w_lane  = QUAD;
                w_qaddr = 1'b1;
                w_dn    = 8'(QIO_DUMMY);
            end
`endif
            (w_cmd_nx == OP_RDID): begin
                w_ok   = 1'b1;
                w_rdid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_lane     <= SINGLE;
            r_qaddr    <= 1'b0;
            r_rdid     <= 1'b0;
            r_dummy_n  <= '0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_id       <= '0;
            r_ld       <= 1'b0;
            r_dq_o     <= '0;
            r_dq_oe    <= '0;
            r_rd_en    <= 1'b0;
            r_mem_addr <= '0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_rd_en   <= 1'b0;
            r_cmd_err <= 1'b0;
            r_ld      <= r_rd_en;
            if (r_ld) r_shift <= mem_rdata;
            if (w_cs_rise) begin
                // partial byte and pending fetch are dropped
                r_state <= ST_IDLE;
                r_dq_o  <= '0;
                r_dq_oe <= '0;
                r_cnt   <= '0;
                r_bit   <= '0;
                r_ld    <= 1'b0;
            end else if (w_cs_fall) begin
                r_state <= ST_CMD;
                r_cnt   <= '0;
                r_bit   <= '0;
                r_id    <= '0;
            end else if (w_sck_rise) begin
                unique case (r_state)
                    ST_CMD: begin
                        r_cmd <= w_cmd_nx[6:0];
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'd7) begin
                            r_cnt     <= '0;
                            r_lane    <= w_lane;
                            r_qaddr   <= w_qaddr;
                            r_rdid    <= w_rdid;
                            r_dummy_n <= w_dn;
                            if (!w_ok) begin
                                r_cmd_err <= 1'b1;
                                r_state   <= ST_IGNORE;
                            end else if (w_rdid) begin
                                r_shift <= id_byte(JEDEC_ID, 2'd0);
                                r_id    <= 2'd1;
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_ADDR;
                            end
                        end
                    end
                    ST_ADDR: begin
                        r_addr <= w_addr_nx[MEM_AW-2:0];
                        r_cnt  <= r_cnt + 8'd1;
                        if (r_cnt == w_alast) begin
                            r_cnt      <= '0;
                            r_rd_en    <= 1'b1;
                            r_mem_addr <= w_addr_nx;
                            r_state    <= (r_dummy_n == 8'd0)
                                          ? ST_DATA : ST_DUMMY;
                        end
                    end
                    ST_DUMMY: begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == r_dummy_n - 8'd1) begin
                            r_cnt   <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                    default: ;
                endcase
            end else if (w_sck_fall && r_state == ST_DATA) begin
                if (r_lane == QUAD) begin
                    r_dq_o  <= r_shift[7:4];
                    r_dq_oe <= 4'b1111;
                    r_shift <= {r_shift[3:0], 4'h0};
                end else begin
                    r_dq_o  <= {2'b00, r_shift[7], 1'b0};
                    r_dq_oe <= 4'b0010;
                    r_shift <= {r_shift[6:0], 1'b0};
                end
                r_bit <= r_bit + 3'd1;
                if (w_last_bit) begin
                    r_bit <= '0;
                    if (r_rdid) begin
                        r_shift <= id_byte(JEDEC_ID, r_id);
                        r_id    <= (r_id == 2'd2) ? 2'd0 : r_id + 2'd1;
                    end else begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                        r_rd_en    <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.qspi_dq_o  = r_dq_o;
    assign bus.qspi_dq_oe = r_dq_oe;
    assign mem_rd_en      = r_rd_en;
    assign mem_addr       = r_mem_addr;
    assign busy           = ~w_cs;
    assign cmd_err        = r_cmd_err;
endmodule

// File: tb/tb_qspi_flash_emu.sv
// tb_qspi_flash_emu: directed QSPI master with a byte scoreboard
// fed by the stimulus and drained by an sck-edge monitor.
module tb_qspi_flash_emu;
    import qspi_flash_emu_pkg::*;

    localparam int HALF = 8;

    typedef struct {
        logic [7:0] d;
        logic [3:0] oe;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_rd_en;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        cmd_err;

    qspi_flash_emu_if bus ();

    qspi_flash_emu dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    bit [7:0] img [0:(1<<20)-1];
    exp_t     exp_q [$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       err_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= img[mem_addr];
    end

    always @(negedge clk) begin
        if (cmd_err) err_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] oe);
        exp_t e;
        e.d  = d;
        e.oe = oe;
        exp_q.push_back(e);
    endtask

    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] oe);
        bus.qspi_dq_i = d;
        repeat (HALF) @(negedge clk);
        bus.qspi_sck = 1'b1;
        oe = bus.qspi_dq_oe;
        repeat (HALF) @(negedge clk);
        bus.qspi_sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] op, input logic [31:0] addr,
                        input int amode, input int ndum, input int ndat);
        logic [3:0] pre;
        logic [3:0] s;
        pre = 4'h0;
        bus.qspi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("busy_on", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            sck_cycle({3'b000, op[7-i]}, s);
            pre |= s;
        end
        if (amode == 1) begin
            for (int i = 0; i < 24; i++) begin
                sck_cycle({3'b000, addr[23-i]}, s);
                pre |= s;
            end
        end else if (amode == 4) begin
            for (int i = 0; i < 6; i++) begin
                sck_cycle(addr[23-4*i -: 4], s);
                pre |= s;
            end
        end
        for (int i = 0; i < ndum; i++) begin
            sck_cycle(4'h0, s);
            pre |= s;
        end
        check("pre_oe", 32'(pre), 32'd0);
        for (int i = 0; i < ndat; i++) sck_cycle(4'h0, s);
        repeat (HALF) @(negedge clk);
        bus.qspi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("cs_oe", 32'(bus.qspi_dq_oe), 32'd0);
        repeat (HALF) @(negedge clk);
        check("busy_off", 32'(busy), 32'd0);
    endtask

    // monitor: assemble bytes from driven lanes, compare in order
    initial begin
        logic [7:0] sh;
        logic [3:0] oe0;
        int         nb;
        bit         bad;
        exp_t       e;
        sh  = 8'h00;
        oe0 = 4'h0;
        nb  = 0;
        bad = 1'b0;
        forever begin
            @(posedge bus.qspi_sck or posedge bus.qspi_cs_n);
            if (bus.qspi_cs_n === 1'b1) begin
                nb = 0;
            end else if (bus.qspi_dq_oe != 4'h0) begin
                if (nb == 0) begin
                    oe0 = bus.qspi_dq_oe;
                    bad = 1'b0;
                end else if (bus.qspi_dq_oe != oe0) begin
                    bad = 1'b1;
                end
                if (bus.qspi_dq_oe == 4'hF) begin
                    sh = {sh[3:0], bus.qspi_dq_o};
                    nb += 4;
                end else begin
                    sh = {sh[6:0], bus.qspi_dq_o[1]};
                    nb += 1;
                end
                if (nb >= 8) begin
                    nb = 0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL byte: got %h oe %b, none expected",
                                 sh, oe0);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e.d || oe0 !== e.oe || bad) begin
                            n_bad++;
                            $display("FAIL byte: got %h oe %b (mixed %0d) want %h oe %b",
                                     sh, oe0, bad, e.d, e.oe);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int e0;
        logic [3:0] s;
        rst = 1'b1;
        bus.qspi_cs_n = 1'b1;
        bus.qspi_sck  = 1'b0;
        bus.qspi_dq_i = 4'h0;
        mem_rdata = 8'h00;
        img[20'h00010] = 8'hDE;
        img[20'h00011] = 8'hAD;
        img[20'h00012] = 8'hBE;
        img[20'h00013] = 8'hEF;
        img[20'h00000] = 8'h3C;
        img[20'h00001] = 8'h96;
        img[20'hFFFFE] = 8'h5A;
        img[20'hFFFFF] = 8'hC3;
        repeat (4) @(negedge clk);
        check("rst_dq", 32'({bus.qspi_dq_o, bus.qspi_dq_oe}), 32'd0);
        check("rst_ctl", 32'({mem_rd_en, busy, cmd_err}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        push(8'hDE, 4'b0010);
        push(8'hAD, 4'b0010);
        push(8'hBE, 4'b0010);
        push(8'hEF, 4'b0010);
        xfer(8'h03, 32'h000010, 1, 0, 32);

        push(8'h3C, 4'b0010);
        xfer(8'h0B, 32'h000000, 1, 8, 8);

        e0 = err_cnt;
`ifdef QSPI_FLASH_EMU_QUAD_EN
        push(8'h5A, 4'b1111);
        push(8'hC3, 4'b1111);
        push(8'h3C, 4'b1111);
        push(8'h96, 4'b1111);
        xfer(8'hEB, 32'h0FFFFE, 4, 6, 8);
        check("eb_err", 32'(err_cnt - e0), 32'd0);
`else
        xfer(8'hEB, 32'h0FFFFE, 0, 16, 0);
        check("eb_err", 32'(err_cnt - e0), 32'd1);
`endif

        push(8'hEF, 4'b0010);
        push(8'h40, 4'b0010);
        push(8'h18, 4'b0010);
        push(8'hEF, 4'b0010);
        push(8'h40, 4'b0010);
        push(8'h18, 4'b0010);
        xfer(8'h9F, 32'h0, 0, 0, 48);

        e0 = err_cnt;
        xfer(8'h05, 32'h0, 0, 16, 0);
        check("op05_err", 32'(err_cnt - e0), 32'd1);
        push(8'hDE, 4'b0010);
        push(8'hAD, 4'b0010);
        push(8'hBE, 4'b0010);
        push(8'hEF, 4'b0010);
        xfer(8'h03, 32'h000010, 1, 0, 32);

        push(8'hDE, 4'b0010);
        xfer(8'h03, 32'h000010, 1, 0, 11);

        bus.qspi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sck_cycle({3'b000, OP_READ[7-i]}, s);
        end
        for (int i = 0; i < 10; i++) sck_cycle(4'h0, s);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_oe", 32'(bus.qspi_dq_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        bus.qspi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        push(8'hBE, 4'b0010);
        push(8'hEF, 4'b0010);
        xfer(8'h03, 32'h000012, 1, 0, 16);

        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL byte: got nothing want %h oe %b", e.d, e.oe);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qspi_flash_emu.md
# qspi_flash_emu

Synthesizable QSPI NOR-flash slave emulator, oversampled on the system clock, used in SoC benches and FPGA prototypes in place of the behavioural flash model so the E203 boot path can fetch code from the QSPI pads. Decodes read-class commands on the serial bus and fetches bytes through a simple synchronous byte-read port into an external RAM/ROM image. Parametrised in address width, image depth, dummy cycles and JEDEC ID; adds quad-output and quad-I/O modes.

## Interface
- ADDR_W, 24: bus address bits clocked in per command (24 or 32).
- MEM_AW, 20: byte-address width of the backing image; bus address aliased modulo 2^MEM_AW.
- FAST_DUMMY, 8: dummy SCK cycles for 0x0B and 0x6B.
- QIO_DUMMY, 6: SCK cycles after quad address for 0xEB (mode + dummy).
- JEDEC_ID, 24'hEF4018: bytes returned by 0x9F, MSB first.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- qspi_cs_n  in  1  chip select, async to clk.
- qspi_sck  in  1  SPI clock, mode 0, async to clk.
- qspi_dq_i  in  4  pad inputs dq3..dq0.
- qspi_dq_o  out  4  pad output values.
- qspi_dq_oe  out  4  per-bit output enable.
- mem_rd_en  out  1  one-cycle byte read strobe.
- mem_addr  out  MEM_AW  byte address.
- mem_rdata  in  8  read data, valid exactly one clk after mem_rd_en.
- busy  out  1  high while cs_n low (synchronized).
- cmd_err  out  1  one-cycle pulse on unsupported opcode.

## Operation
- cs_n, sck, dq_i pass through 2-flop synchronizers; sck rise/fall and cs_n fall/rise derived from synchronized history.
- States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- IDLE -> CMD on cs_n fall; bit/byte counters cleared.
- CMD: 8 bits on dq0 at sck rise, MSB first. Decode:
  - 0x03 read: ADDR single, no dummy, single data on dq1.
  - 0x0B fast read: ADDR single, FAST_DUMMY, single data.
  - 0x6B quad output: ADDR single, FAST_DUMMY, data on dq3..dq0 (high nibble first).
  - 0xEB quad I/O: ADDR on dq3..dq0 (ADDR_W/4 clocks), QIO_DUMMY, quad data.
  - 0x9F: DATA sourced from JEDEC_ID, 3 bytes then repeats.
  - other: cmd_err pulse, IGNORE.
- ADDR -> DUMMY (or DATA if dummy count 0) after last address bit; mem_rd_en issued the following clk with mem_addr = addr[MEM_AW-1:0].
- DATA: shift register loaded from mem_rdata; bits/nibbles driven after each sck fall; first bit driven after the fall following last address/dummy rise. On byte-complete, address increments and the next read is issued at once; address wraps 2^MEM_AW-1 -> 0.
- Output enables: single mode oe=4'b0010; quad mode oe=4'b1111; all other states oe=0.
- IGNORE holds until cs_n rise. cs_n rise in any state -> IDLE next clk, oe=0, counters cleared; partial byte discarded.
- rst has priority over all events; cs_n fall and cs_n rise never both in one clk (synchronizer guarantees).

## Timing
- Reset values: qspi_dq_o=0, qspi_dq_oe=0, mem_rd_en=0, mem_addr=0, busy=0, cmd_err=0, state IDLE.
- Pad-in to internal edge: 3 clk (2 sync + 1 edge detect). Output change: ≤4 clk after external sck fall.
- Requirement: sck high and low phases each ≥ 6 clk; slower sck always valid.
- mem read issued 1 clk after address/byte completion; data registered 1 clk later; always before next driving fall under the above constraint.
- oe drops within 4 clk of external cs_n rise.

## Configuration
- QSPI_FLASH_EMU_QUAD_EN defined: 0x6B and 0xEB supported, quad datapath and 4-bit oe built.
- Undefined: 0x6B/0xEB decode as unsupported (cmd_err, IGNORE); qspi_dq_oe[3:2,0] tied 0; QIO_DUMMY unused.

## Structure
- Package qspi_flash_emu_pkg: state enum, opcode constants (OP_READ, OP_FAST, OP_QOUT, OP_QIO, OP_RDID), lane-mode enum (SINGLE, QUAD).
- One sub-module: qspi_emu_sync (2-flop synchronizer + rise/fall detect, width parameter), instanced for cs_n, sck, dq.

## Test plan
- 0x03, addr 0x000010, image[0x10..0x13]=DE AD BE EF, 32 sck -> dq1 serial bytes DE AD BE EF; oe=0010 only during data.
- 0x0B addr 0x000000, FAST_DUMMY=8 -> dq1 high-Z for 8 clocks, then image[0].
- 0xEB quad addr 0x0FFFFE, MEM_AW=20, 4 bytes -> image[FFFFE], image[FFFFF], image[0], image[1] (wrap).
- 0x9F, 48 sck -> EF 40 18 EF 40 18.
- Opcode 0x05 -> cmd_err one pulse, oe stays 0 until cs_n rise; next 0x03 works.
- cs_n rise mid-byte at bit 3 of data, and rst asserted mid-ADDR -> oe=0 within 4 clk, state IDLE, next command decodes correctly.
